// File: rtl/lv_owt_pkg.sv
// Shared one-wire link definitions for the tx framer and the receiver: FSM states, field widths, tail and ADC codes.
// Pure declarations; no timing or flow control of its own.
package lv_owt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC_HEAD,
    ST_SYNC_TAIL,
    ST_CMD,
    ST_ADC_DATA,
    ST_NML_DATA,
    ST_CRC,
    ST_END_TAIL
  } owt_state_e;

  localparam int OWT_CMD_W  = 8;
  localparam int OWT_DATA_W = 8;
  localparam int OWT_ADCD_W = 10;
  localparam int OWT_CRC_W  = 8;
  localparam int OWT_TAIL_W = 4;

  localparam logic [3:0] OWT_TAIL_PAT = 4'b1100;
  localparam logic [6:0] OWT_ADC_CMD  = 7'h1F;
  localparam logic [7:0] OWT_CRC_POLY = 8'h07;

  // A read of the ADC register carries a wide data field.
  function automatic logic owt_is_adc(input logic [7:0] cmd);
    return !cmd[7] && (cmd[6:0] == OWT_ADC_CMD);
  endfunction

endpackage

// File: rtl/lv_owt_crc8_ser.sv
// Serial CRC-8 (poly 0x07, init 0): absorbs one bit per enabled clock, result valid the cycle after.
// No flow control; clear has priority over enable.
module lv_owt_crc8_ser
  import lv_owt_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_din,
  output logic [7:0] o_crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ i_din) ? OWT_CRC_POLY : 8'h00);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      crc_q <= 8'h00;
    end else if (i_en) begin
      crc_q <= crc_d;
    end
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/lv_owt_tx_framer.sv
// One-wire Manchester tx framer: line changes one clock after acceptance, ack one clock after the last half-bit.
// Requests are ignored while busy; OWT_TX_ABORT_EN adds an abort input and completion status output.
module lv_owt_tx_framer
  import lv_owt_pkg::*;
#(
  parameter int OWT_EXT_CYC_NUM  = 8,
  parameter int OWT_SYNC_BIT_NUM = 12,
  parameter int OWT_CMD_BIT_NUM  = OWT_CMD_W,
  parameter int OWT_DATA_BIT_NUM = OWT_DATA_W,
  parameter int OWT_ADCD_BIT_NUM = OWT_ADCD_W,
  parameter int OWT_CRC_BIT_NUM  = OWT_CRC_W,
  parameter int OWT_TAIL_BIT_NUM = OWT_TAIL_W
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_owt_tx_req,
  input  logic [OWT_CMD_BIT_NUM-1:0]  i_owt_tx_cmd,
  input  logic [OWT_ADCD_BIT_NUM-1:0] i_owt_tx_data,
`ifdef OWT_TX_ABORT_EN
  input  logic                        i_owt_tx_abort,
  output logic                        o_owt_tx_status,
`endif
  output logic                        o_owt_tx_busy,
  output logic                        o_owt_tx_ack,
  output logic                        o_lv_hv_owt_tx
);

  localparam int CNT_W = (OWT_EXT_CYC_NUM > 1) ? $clog2(OWT_EXT_CYC_NUM) : 1;
  localparam int SH_W  = OWT_ADCD_BIT_NUM;

  owt_state_e                  state_q, st_d, st_nxt;
  logic [CNT_W-1:0]            cnt_q;
  logic [1:0]                  hb_q, hb_d;
  logic [4:0]                  idx_q, idx_d, nbits;
  logic [SH_W-1:0]             sh_q, sh_d;
  logic [OWT_CMD_BIT_NUM-1:0]  cmd_q;
  logic [OWT_ADCD_BIT_NUM-1:0] data_q;
  logic                        manch, lvl_d;
  logic                        line_q, busy_q, ack_q;
  logic                        accept, half_end, crc_en;
  logic [7:0]                  crc;
`ifdef OWT_TX_ABORT_EN
  logic                        status_q;
`endif

  // busy_q stays high through the ack cycle, which also blocks re-acceptance there.
  assign accept   = (state_q == ST_IDLE) && i_owt_tx_req && !busy_q;
  assign half_end = (cnt_q == CNT_W'(OWT_EXT_CYC_NUM - 1));
  assign crc_en   = (state_q inside {ST_CMD, ST_ADC_DATA, ST_NML_DATA}) &&
                    (hb_q == 2'd0) && (cnt_q == '0);

  lv_owt_crc8_ser u_crc (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (accept),
    .i_en  (crc_en),
    .i_din (sh_q[SH_W-1]),
    .o_crc (crc)
  );

  always_comb begin
    nbits  = '0;
    st_nxt = ST_IDLE;
    manch  = 1'b1;
    case (state_q)
      ST_SYNC_HEAD: begin nbits = 5'(OWT_SYNC_BIT_NUM); st_nxt = ST_SYNC_TAIL; end
      ST_SYNC_TAIL: begin manch = 1'b0; st_nxt = ST_CMD; end
      ST_CMD: begin
        nbits  = 5'(OWT_CMD_BIT_NUM);
        st_nxt = owt_is_adc(cmd_q[7:0]) ? ST_ADC_DATA : ST_NML_DATA;
      end
      ST_ADC_DATA:  begin nbits = 5'(OWT_ADCD_BIT_NUM); st_nxt = ST_CRC; end
      ST_NML_DATA:  begin nbits = 5'(OWT_DATA_BIT_NUM); st_nxt = ST_CRC; end
      ST_CRC:       begin nbits = 5'(OWT_CRC_BIT_NUM);  st_nxt = ST_END_TAIL; end
      default:      begin manch = 1'b0; st_nxt = ST_IDLE; end
    endcase

    // Position of the half-bit that follows the current one.
    st_d  = state_q;
    hb_d  = hb_q + 2'd1;
    idx_d = idx_q;
    if (manch) begin
      if (hb_q[0]) begin
        hb_d = 2'd0;
        if (idx_q == nbits - 5'd1) begin
          st_d  = st_nxt;
          idx_d = 5'd0;
        end else begin
          idx_d = idx_q + 5'd1;
        end
      end
    end else if (hb_q == 2'(OWT_TAIL_BIT_NUM - 1)) begin
      st_d = st_nxt;
      hb_d = 2'd0;
    end

    // Field shifter keeps the bit being sent at its MSB.
    sh_d = sh_q;
    if (st_d != state_q) begin
      case (st_d)
        ST_CMD:      sh_d = SH_W'(cmd_q) << (SH_W - OWT_CMD_BIT_NUM);
        ST_ADC_DATA: sh_d = data_q;
        ST_NML_DATA: sh_d = SH_W'(data_q[OWT_DATA_BIT_NUM-1:0]) << (SH_W - OWT_DATA_BIT_NUM);
        ST_CRC:      sh_d = SH_W'(crc) << (SH_W - OWT_CRC_BIT_NUM);
        default:     sh_d = '0;
      endcase
    end else if (manch && hb_q[0]) begin
      sh_d = sh_q << 1;
    end

    case (st_d)
      ST_IDLE:                  lvl_d = 1'b1;
      ST_SYNC_TAIL, ST_END_TAIL: lvl_d = OWT_TAIL_PAT[2'd3 - hb_d];
      default:                  lvl_d = hb_d[0] ? sh_d[SH_W-1] : ~sh_d[SH_W-1];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hb_q     <= 2'd0;
      idx_q    <= 5'd0;
      sh_q     <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
`ifdef OWT_TX_ABORT_EN
      status_q <= 1'b0;
`endif
    end else begin
      ack_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        busy_q <= 1'b0;
        line_q <= 1'b1;
        cnt_q  <= '0;
        hb_q   <= 2'd0;
        idx_q  <= 5'd0;
        sh_q   <= '0;
        if (accept) begin
          state_q <= ST_SYNC_HEAD;
          busy_q  <= 1'b1;
          cmd_q   <= i_owt_tx_cmd;
          data_q  <= i_owt_tx_data;
        end
`ifdef OWT_TX_ABORT_EN
      end else if (i_owt_tx_abort) begin
        state_q  <= ST_IDLE;
        line_q   <= 1'b1;
        ack_q    <= 1'b1;
        status_q <= 1'b1;
`endif
      end else if (half_end) begin
        cnt_q   <= '0;
        state_q <= st_d;
        hb_q    <= hb_d;
        idx_q   <= idx_d;
        sh_q    <= sh_d;
        line_q  <= lvl_d;
        if (st_d == ST_IDLE) begin
          ack_q <= 1'b1;
`ifdef OWT_TX_ABORT_EN
          status_q <= 1'b0;
`endif
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_lv_hv_owt_tx = line_q;
  assign o_owt_tx_busy  = busy_q;
  assign o_owt_tx_ack   = ack_q;
`ifdef OWT_TX_ABORT_EN
  assign o_owt_tx_status = status_q;
`endif

endmodule

// File: tb/tb_lv_owt_tx_framer.sv
// Directed bench for lv_owt_tx_framer: expected half-bit levels are queued at request time and
// popped as the line is sampled on the falling clock edge.
module tb_lv_owt_tx_framer;

  localparam int HB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [7:0] cmd_i;
  logic [9:0] dat_i;
  logic       busy, ack, line;
`ifdef OWT_TX_ABORT_EN
  logic       abort, status;
`endif

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  lv_owt_tx_framer dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_owt_tx_req    (req),
    .i_owt_tx_cmd    (cmd_i),
    .i_owt_tx_data   (dat_i),
`ifdef OWT_TX_ABORT_EN
    .i_owt_tx_abort  (abort),
    .o_owt_tx_status (status),
`endif
    .o_owt_tx_busy   (busy),
    .o_owt_tx_ack    (ack),
    .o_lv_hv_owt_tx  (line)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  // Manchester: '0' is high then low, '1' is low then high.
  task automatic push_man(input logic b);
    exp_q.push_back(!b);
    exp_q.push_back(b);
  endtask

  task automatic push_tail();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
  endtask

  task automatic push_frame(input logic [7:0] cmd, input logic [9:0] dat,
                            input logic fixed, input logic [7:0] fixed_crc);
    logic [7:0] crc;
    int         nd;
    crc = 8'h00;
    nd  = (!cmd[7] && cmd[6:0] == 7'h1F) ? 10 : 8;
    repeat (12) push_man(1'b0);
    push_tail();
    for (int i = 7; i >= 0; i--) begin
      push_man(cmd[i]);
      crc = crc8(crc, cmd[i]);
    end
    for (int i = nd - 1; i >= 0; i--) begin
      push_man(dat[i]);
      crc = crc8(crc, dat[i]);
    end
    if (fixed) crc = fixed_crc;
    for (int i = 7; i >= 0; i--) push_man(crc[i]);
    push_tail();
  endtask

  // Entered just after a falling edge with the DUT able to accept; returns just after a falling edge.
  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [9:0] dat,
                           input logic hold, input logic fixed, input logic [7:0] fcrc,
                           input int cut_at, input logic cut_abort);
    int   len;
    logic cur;
    logic cut;
    cur   = 1'b1;
    cut   = 1'b0;
    req   = 1'b1;
    cmd_i = cmd;
    dat_i = dat;
    push_frame(cmd, dat, fixed, fcrc);
    len = exp_q.size() * HB;
    for (int c = 1; c <= len && !cut; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) req = 1'b0;
      if (c == 100) begin
        cmd_i = ~cmd;
        dat_i = ~dat;
      end
      if ((c - 1) % HB == 0) cur = exp_q.pop_front();
      chk({tag, "_line"}, 32'({busy, ack, line}), 32'({1'b1, 1'b0, cur}));
      if (c == cut_at) begin
        cut = 1'b1;
`ifdef OWT_TX_ABORT_EN
        if (cut_abort) abort = 1'b1;
        else rst = 1'b1;
`else
        rst = 1'b1;
`endif
        @(negedge clk);
        chk({tag, "_cut"}, 32'({busy, ack, line}), 32'({cut_abort, cut_abort, 1'b1}));
`ifdef OWT_TX_ABORT_EN
        chk({tag, "_cut_status"}, 32'(status), 32'(cut_abort));
        abort = 1'b0;
`endif
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk({tag, "_cut_idle"}, 32'({busy, ack, line}), 32'({1'b0, 1'b0, 1'b1}));
      end
    end
    if (!cut) begin
      @(negedge clk);
      chk({tag, "_ack"}, 32'({busy, ack, line}), 32'({1'b1, 1'b1, 1'b1}));
`ifdef OWT_TX_ABORT_EN
      chk({tag, "_status"}, 32'(status), 32'(1'b0));
`endif
      @(negedge clk);
      chk({tag, "_done"}, 32'({busy, ack, line}), 32'({1'b0, 1'b0, 1'b1}));
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = 1'b0;
    cmd_i = 8'h00;
    dat_i = 10'h000;
`ifdef OWT_TX_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset", 32'({busy, ack, line}), 32'({1'b0, 1'b0, 1'b1}));
`ifdef OWT_TX_ABORT_EN
    chk("reset_status", 32'(status), 32'(1'b0));
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("idle", 32'({busy, ack, line}), 32'({1'b0, 1'b0, 1'b1}));

    run_frame("wr85",  8'h85, 10'h03C, 1'b0, 1'b1, 8'h43, 0, 1'b0);
    run_frame("adc1f", 8'h1F, 10'h2A5, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    run_frame("rd05",  8'h05, 10'h3AB, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    run_frame("wr9f",  8'h9F, 10'h155, 1'b0, 1'b0, 8'h00, 0, 1'b0);
    run_frame("hold1", 8'hC3, 10'h096, 1'b1, 1'b0, 8'h00, 0, 1'b0);
    run_frame("hold2", 8'h1F, 10'h1C3, 1'b1, 1'b0, 8'h00, 0, 1'b0);
    req = 1'b0;
    run_frame("rst",   8'h85, 10'h03C, 1'b0, 1'b0, 8'h00, 300, 1'b0);
    run_frame("clean", 8'h5A, 10'h0F0, 1'b0, 1'b0, 8'h00, 0, 1'b0);
`ifdef OWT_TX_ABORT_EN
    run_frame("abort", 8'h33, 10'h0CC, 1'b0, 1'b0, 8'h00, 200, 1'b1);
    run_frame("post_abort", 8'h1F, 10'h3FF, 1'b0, 1'b0, 8'h00, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
